// File: rtl/sample_player_mc_if.sv
// Sample ROM bus: registered address and read strobe out, unsigned 8-bit data back.
interface sample_player_mc_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [7:0]        rom_data;

    modport master (output rom_addr, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_rd, output rom_data);
endinterface

// File: rtl/sample_player_mc.sv
// Multi-channel PCM sample player: time-division ROM fetch per channel,
// signed accumulate, saturating mix to one 16-bit output per sample period.
module sample_player_mc #(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 16,
    parameter int RATE_DIV = 1632
) (
    input  logic                         CLK_18M,
    input  logic                         RESET_n,
    input  logic [CHANNELS-1:0]          trigger,
    input  logic [CHANNELS-1:0]          loop,
    input  logic [CHANNELS*ADDR_W-1:0]   start_addr,
    input  logic [CHANNELS*ADDR_W-1:0]   length,
    sample_player_mc_if.master           rom,
    output logic [15:0]                  audio_out,
    output logic                         sample_strobe,
    output logic [CHANNELS-1:0]          active
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ACC_W = 16 + $clog2(CHANNELS);
    localparam int DIV_W = $clog2(RATE_DIV);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, ACC, OUT} state_t;

    state_t                     state;
    logic [DIV_W-1:0]           div;
    logic                       tick;
    logic [CH_W-1:0]            ch;
    logic signed [ACC_W-1:0]    acc;
    logic [CHANNELS-1:0]        trig_prev;
    logic [CHANNELS-1:0]        pending;
    logic [ADDR_W-1:0]          pos [CHANNELS];

    logic [CHANNELS-1:0]        rise;
    logic [CHANNELS-1:0]        pend_clr;
    logic [ADDR_W-1:0]          cur_start;
    logic [ADDR_W-1:0]          cur_len;
    logic [ADDR_W-1:0]          cur_pos;
    logic                       start_now;
    logic                       fetch_act;
    logic [ADDR_W-1:0]          fetch_pos;
    logic signed [ACC_W-1:0]    sample_ext;
    logic [15:0]                sat;

    assign tick = (div == DIV_W'(RATE_DIV - 1));

    // Sample-rate divider, free running 0..RATE_DIV-1.
    always_ff @(posedge CLK_18M or negedge RESET_n) begin
        if (!RESET_n) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
        end
    end

    // Per-slot decode: current channel fields, restart decision, sample scaling and saturation.
    always_comb begin
        rise       = trigger & ~trig_prev;
        pend_clr   = '0;
        if (state == FETCH) begin
            pend_clr[ch] = 1'b1;
        end
        cur_start  = start_addr[ch*ADDR_W +: ADDR_W];
        cur_len    = length[ch*ADDR_W +: ADDR_W];
        cur_pos    = pos[ch];
        start_now  = pending[ch] && (cur_len != '0);
        fetch_act  = active[ch] | start_now;
        fetch_pos  = start_now ? '0 : cur_pos;
        // (data - 128) << 8 is the offset-binary byte with its MSB flipped, placed in the high byte.
        sample_ext = ACC_W'($signed({rom.rom_data ^ 8'h80, 8'h00}));
        if (acc > ACC_W'(32767)) begin
            sat = 16'h7FFF;
        end else if (acc < ACC_W'(-32768)) begin
            sat = 16'h8000;
        end else begin
            sat = acc[15:0];
        end
    end

    // Slot sequencer: trigger capture, per-channel fetch/accumulate, and mixed output.
    always_ff @(posedge CLK_18M or negedge RESET_n) begin
        if (!RESET_n) begin
            state         <= IDLE;
            ch            <= '0;
            acc           <= '0;
            trig_prev     <= '1;
            pending       <= '0;
            active        <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pos[i] <= '0;
            end
            rom.rom_addr  <= '0;
            rom.rom_rd    <= 1'b0;
            audio_out     <= '0;
            sample_strobe <= 1'b0;
        end else begin
            trig_prev     <= trigger;
            // A rise in the same cycle as its channel's fetch is kept for the next period.
            pending       <= (pending & ~pend_clr) | rise;
            sample_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        acc   <= '0;
                        ch    <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    active[ch] <= fetch_act;
                    pos[ch]    <= fetch_pos;
                    rom.rom_rd <= fetch_act;
                    if (fetch_act) begin
                        rom.rom_addr <= cur_start + fetch_pos;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    rom.rom_rd <= 1'b0;
                    state      <= ACC;
                end
                ACC: begin
                    if (active[ch]) begin
                        acc <= acc + sample_ext;
                        if (cur_pos == cur_len - ADDR_W'(1)) begin
                            pos[ch]    <= '0;
                            active[ch] <= loop[ch];
                        end else begin
                            pos[ch] <= cur_pos + ADDR_W'(1);
                        end
                    end
                    if (ch == CH_W'(CHANNELS - 1)) begin
                        state <= OUT;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        state <= FETCH;
                    end
                end
                OUT: begin
                    audio_out     <= sat;
                    sample_strobe <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_player_mc.sv
// Directed bench for sample_player_mc with a synchronous ROM model.
module tb_sample_player_mc;
    localparam int CH = 4;
    localparam int AW = 16;
    localparam int RD = 16;

    logic              CLK_18M = 1'b0;
    logic              RESET_n;
    logic [CH-1:0]     trigger;
    logic [CH-1:0]     loop;
    logic [CH*AW-1:0]  start_addr;
    logic [CH*AW-1:0]  length;
    logic [15:0]       audio_out;
    logic              sample_strobe;
    logic [CH-1:0]     active;

    int checks = 0;
    int errors = 0;

    logic [7:0]    mem [0:65535];
    logic [AW-1:0] addr_q = '0;
    logic [AW-1:0] rd_log [$];

    sample_player_mc_if #(.ADDR_W(AW)) rom_bus ();

    sample_player_mc #(.CHANNELS(CH), .ADDR_W(AW), .RATE_DIV(RD)) dut (
        .CLK_18M       (CLK_18M),
        .RESET_n       (RESET_n),
        .trigger       (trigger),
        .loop          (loop),
        .start_addr    (start_addr),
        .length        (length),
        .rom           (rom_bus),
        .audio_out     (audio_out),
        .sample_strobe (sample_strobe),
        .active        (active)
    );

    always #5 CLK_18M = ~CLK_18M;

    // Synchronous ROM: address registered on a read, data available the following cycle.
    always @(posedge CLK_18M) begin
        if (rom_bus.rom_rd) addr_q <= rom_bus.rom_addr;
    end
    assign rom_bus.rom_data = mem[addr_q];

    // Log of every address presented with rom_rd high.
    always @(posedge CLK_18M) begin
        if (rom_bus.rom_rd) rd_log.push_back(rom_bus.rom_addr);
    end

    task automatic wait_strobe(output logic [15:0] v);
        int n;
        n = 0;
        v = '0;
        @(negedge CLK_18M);
        while (!sample_strobe && n < 200) begin
            @(negedge CLK_18M);
            n++;
        end
        if (!sample_strobe) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: no sample_strobe within 200 cycles");
        end else begin
            v = audio_out;
        end
    endtask

    task automatic set_ch(input int i, input logic [AW-1:0] s, input logic [AW-1:0] l);
        start_addr[i*AW +: AW] = s;
        length[i*AW +: AW]     = l;
    endtask

    task automatic pulse(input logic [CH-1:0] m);
        trigger = trigger | m;
        @(negedge CLK_18M);
        trigger = trigger & ~m;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        RESET_n    = 1'b0;
        trigger    = '1;
        loop       = '0;
        start_addr = '0;
        length     = '0;
        for (int i = 0; i < CH; i++) set_ch(i, 16'h0100, 16'd4);
        repeat (3) @(negedge CLK_18M);
        checks++; if (audio_out !== 16'h0000) begin errors++; $display("FAIL reset_audio got %h exp 0000", audio_out); end
        checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", sample_strobe); end
        checks++; if (rom_bus.rom_rd !== 1'b0) begin errors++; $display("FAIL reset_rom_rd got %b exp 0", rom_bus.rom_rd); end
        checks++; if (rom_bus.rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_rom_addr got %h exp 0000", rom_bus.rom_addr); end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_active got %b exp 0000", active); end
        RESET_n = 1'b1;
        rd_log.delete();
        wait_strobe(v);
        wait_strobe(v);
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_held_trigger_active got %b exp 0000", active); end
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_held_trigger_audio got %h exp 0000", v); end
        checks++; if (rd_log.size() != 0) begin errors++; $display("FAIL reset_held_trigger_reads got %0d exp 0", rd_log.size()); end
        trigger = '0;
        for (int i = 0; i < CH; i++) set_ch(i, 16'h0000, 16'd0);
    endtask

    task automatic test_one_shot();
        logic [15:0] v;
        int exp_v [5] = '{0, 32512, -32768, 4096, 0};
        set_ch(0, 16'h0100, 16'd4);
        wait_strobe(v);
        rd_log.delete();
        pulse(4'b0001);
        for (int k = 0; k < 5; k++) begin
            wait_strobe(v);
            checks++;
            if (v !== 16'(exp_v[k])) begin errors++; $display("FAIL one_shot_out[%0d] got %0d exp %0d", k, $signed(v), exp_v[k]); end
            if (k == 2) begin
                checks++; if (active[0] !== 1'b1) begin errors++; $display("FAIL one_shot_active_mid got %b exp 1", active[0]); end
            end
            if (k == 3) begin
                checks++; if (active !== 4'b0000) begin errors++; $display("FAIL one_shot_active_end got %b exp 0000", active); end
            end
        end
        checks++;
        if (rd_log.size() != 4) begin
            errors++; $display("FAIL one_shot_read_count got %0d exp 4", rd_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rd_log[k] !== 16'(16'h0100 + k)) begin errors++; $display("FAIL one_shot_read_addr[%0d] got %h exp %h", k, rd_log[k], 16'(16'h0100 + k)); end
            end
        end
    endtask

    task automatic test_loop();
        logic [15:0] v;
        int pat [4] = '{0, 32512, -32768, 4096};
        int tail [3] = '{-32768, 4096, 0};
        loop[0] = 1'b1;
        wait_strobe(v);
        pulse(4'b0001);
        for (int k = 0; k < 10; k++) begin
            wait_strobe(v);
            checks++;
            if (v !== 16'(pat[k % 4])) begin errors++; $display("FAIL loop_out[%0d] got %0d exp %0d", k, $signed(v), pat[k % 4]); end
        end
        loop[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(v);
            checks++;
            if (v !== 16'(tail[k])) begin errors++; $display("FAIL loop_drop_out[%0d] got %0d exp %0d", k, $signed(v), tail[k]); end
        end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL loop_drop_active got %b exp 0000", active); end
    endtask

    task automatic test_saturation();
        logic [15:0] v;
        mem[16'h0200] = 8'hFF;
        mem[16'h0300] = 8'h00;
        mem[16'h0400] = 8'hC0;
        for (int i = 0; i < CH; i++) set_ch(i, 16'h0200, 16'd1);
        wait_strobe(v);
        pulse(4'b1111);
        wait_strobe(v);
        checks++; if (v !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_four got %0d exp 32767", $signed(v)); end
        for (int i = 0; i < CH; i++) set_ch(i, 16'h0300, 16'd1);
        wait_strobe(v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL sat_one_shot_silence got %0d exp 0", $signed(v)); end
        pulse(4'b1111);
        wait_strobe(v);
        checks++; if (v !== 16'h8000) begin errors++; $display("FAIL sat_neg_four got %0d exp -32768", $signed(v)); end
        set_ch(0, 16'h0400, 16'd1);
        set_ch(1, 16'h0400, 16'd1);
        wait_strobe(v);
        pulse(4'b0011);
        wait_strobe(v);
        checks++; if (v !== 16'h7FFF) begin errors++; $display("FAIL sat_two_c0 got %0d exp 32767", $signed(v)); end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL sat_active_end got %b exp 0000", active); end
    endtask

    task automatic test_retrigger();
        logic [15:0] v;
        int exp_a [3] = '{256, 512, 768};
        int exp_b [7] = '{256, 512, 768, 1024, 1280, 1536, 0};
        for (int j = 0; j < 6; j++) mem[16'h0500 + j] = 8'(8'h81 + j);
        for (int i = 0; i < CH; i++) set_ch(i, 16'h0000, 16'd0);
        set_ch(1, 16'h0500, 16'd6);
        wait_strobe(v);
        pulse(4'b0010);
        for (int k = 0; k < 3; k++) begin
            wait_strobe(v);
            checks++;
            if (v !== 16'(exp_a[k])) begin errors++; $display("FAIL retrig_first[%0d] got %0d exp %0d", k, $signed(v), exp_a[k]); end
        end
        pulse(4'b0010);
        for (int k = 0; k < 7; k++) begin
            wait_strobe(v);
            checks++;
            if (v !== 16'(exp_b[k])) begin errors++; $display("FAIL retrig_restart[%0d] got %0d exp %0d", k, $signed(v), exp_b[k]); end
        end
    endtask

    task automatic test_len_zero();
        logic [15:0] v;
        set_ch(2, 16'h0600, 16'd0);
        wait_strobe(v);
        rd_log.delete();
        pulse(4'b0100);
        wait_strobe(v);
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL len_zero_active got %b exp 0000", active); end
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL len_zero_audio got %0d exp 0", $signed(v)); end
        checks++; if (rd_log.size() != 0) begin errors++; $display("FAIL len_zero_reads got %0d exp 0", rd_log.size()); end
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        logic [15:0] exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        set_ch(3, 16'hFFFE, 16'd4);
        wait_strobe(v);
        rd_log.delete();
        pulse(4'b1000);
        for (int k = 0; k < 5; k++) wait_strobe(v);
        checks++;
        if (rd_log.size() != 4) begin
            errors++; $display("FAIL wrap_read_count got %0d exp 4", rd_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rd_log[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", k, rd_log[k], exp_a[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        int exp_v [4] = '{0, 32512, -32768, 4096};
        for (int i = 0; i < CH; i++) set_ch(i, 16'h0000, 16'd0);
        set_ch(0, 16'h0100, 16'd4);
        wait_strobe(v);
        pulse(4'b0001);
        wait_strobe(v);
        wait_strobe(v);
        checks++; if (v !== 16'd32512) begin errors++; $display("FAIL mid_pre_audio got %0d exp 32512", $signed(v)); end
        // Five falling edges after the strobe lands inside channel 0's ACC slot.
        repeat (5) @(negedge CLK_18M);
        RESET_n = 1'b0;
        #1;
        checks++; if (audio_out !== 16'h0000) begin errors++; $display("FAIL mid_reset_audio got %0d exp 0", $signed(audio_out)); end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL mid_reset_active got %b exp 0000", active); end
        repeat (3) @(negedge CLK_18M);
        RESET_n = 1'b1;
        wait_strobe(v);
        pulse(4'b0001);
        for (int k = 0; k < 4; k++) begin
            wait_strobe(v);
            checks++;
            if (v !== 16'(exp_v[k])) begin errors++; $display("FAIL mid_replay[%0d] got %0d exp %0d", k, $signed(v), exp_v[k]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h80;
        mem[16'h0100] = 8'h80;
        mem[16'h0101] = 8'hFF;
        mem[16'h0102] = 8'h00;
        mem[16'h0103] = 8'h90;
        test_reset();
        test_one_shot();
        test_loop();
        test_saturation();
        test_retrigger();
        test_len_zero();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_player_mc.md
# sample_player_mc

Parametrised multi-channel PCM sample playback engine for the arcade cores' audio path. It replaces one single-sample player per sound effect with one block that serves N edge-triggered channels from a shared synchronous sample ROM. Channels are read in a fixed time-division slot schedule, then mixed with saturation into one signed output. The output feeds `audio_l`/`audio_r` directly.

## Interface
- CHANNELS, 4: number of independent channels (1–8)
- ADDR_W, 16: sample ROM address width
- RATE_DIV, 1632: CLK_18M cycles per output sample (≈11.3 kHz); must satisfy RATE_DIV ≥ 3*CHANNELS+2
- CLK_18M  in  1  system clock; all state on rising edge
- RESET_n  in  1  asynchronous active-low reset
- trigger  in  CHANNELS  per-channel start request; rising edge (re)starts that channel
- loop  in  CHANNELS  per-channel loop enable, sampled at end of sample
- start_addr  in  CHANNELS*ADDR_W  per-channel first ROM address, channel i at bits [i*ADDR_W +: ADDR_W]
- length  in  CHANNELS*ADDR_W  per-channel sample count, same packing
- rom_addr  out  ADDR_W  sample ROM address
- rom_rd  out  1  ROM read enable
- rom_data  in  8  unsigned 8-bit sample; valid 2 cycles after the FETCH cycle (synchronous ROM, registered address)
- audio_out  out  16  signed mixed sample
- sample_strobe  out  1  one-cycle pulse when audio_out updates
- active  out  CHANNELS  channel i is playing

## Operation
- Divider counts 0..RATE_DIV-1. The tick occurs at count RATE_DIV-1, then the divider wraps to 0.
- Sequencer states: IDLE → (tick) FETCH → WAIT → ACC → (next channel, or OUT after last) → IDLE.
- Every channel slot takes 3 cycles whether the channel is active or not.
- Trigger edge detect: prev register per channel. A rising edge sets pending[i]. Edges between slots are never lost; multiple edges in one period collapse to one.
- FETCH of channel i:
  - If pending[i] and length[i]≠0: pos[i]:=0, active[i]:=1, clear pending. A retrigger during playback restarts at pos 0.
  - If pending[i] and length[i]=0: clear pending, channel stays idle.
  - Then, if active: rom_addr = start_addr[i]+pos[i] (mod 2^ADDR_W), rom_rd=1. If not active: rom_rd=0.
- WAIT: rom_rd=0, rom_addr held.
- ACC for an active channel:
  - acc += (rom_data − 128) << 8, giving a signed range −32768..32512.
  - If pos = length−1: pos:=0; active:=loop[i]. Otherwise pos++.
  - Inactive channels add 0.
- Accumulator width is 16+clog2(CHANNELS), signed, cleared on entry to FETCH of channel 0.
- OUT: audio_out := saturate(acc) to [−32768, 32767]; sample_strobe=1 for that edge only.
- Parameters and port values are read live; changing start_addr/length mid-play takes effect at the next slot.

## Timing
- Reset values: audio_out=0, sample_strobe=0, rom_rd=0, rom_addr=0, active=0, pending=0, divider=0, state IDLE, pos=0.
- The trigger prev register resets to all ones, so a trigger held high through reset does not fire.
- Reset assertion mid-operation aborts immediately to the reset state. The first tick after release is RATE_DIV cycles later.
- Tick edge T:
  - FETCH of channel k is the cycle starting at T+1+3k.
  - rom_data is sampled at the edge ending cycle T+3+3k.
  - audio_out and sample_strobe update at edge T+3*CHANNELS+2.
- A trigger edge registered before FETCH of its channel sounds in that period. A later edge sounds in the next period.
- An active channel advances exactly one sample per period. With loop held at 0, a sample of length L produces exactly L non-silent outputs.

## Test plan
- Reset: hold RESET_n low with trigger=all ones → all outputs at reset values; after release, no channel goes active without a new rising edge.
- One-shot, CHANNELS=4: ch0 start=0x100, length=4, ROM 0x80,0xFF,0x00,0x90 → successive audio_out 0, 32512, −32768, 4096, then 0; active[0] falls after the 4th sample; rom_rd never asserts for ch1–3.
- Loop: same sample with loop[0]=1 for 10 periods → pattern repeats with period 4. Dropping loop mid-sample → playback stops at the next end of sample.
- Saturation: all 4 channels on bytes 0xFF → 32767. All 4 channels on 0x00 → −32768. Two channels on 0xC0 → 32768 clipped to 32767.
- Retrigger and boundaries:
  - Re-pulse ch1 at pos 3 of 6 → next output is from pos 0.
  - length=0 → active stays 0.
  - start=0xFFFE, length=4 → rom_addr sequence FFFE, FFFF, 0000, 0001.
- Reset mid-play: assert RESET_n low during an ACC cycle → audio_out=0 and active=0 immediately; a fresh trigger after release plays from pos 0.
